// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_if
//  Description : Strobe and bus bundle between the CPU control unit (master)
//                and the program counter stage (slave).
//                Master drives : pc_w, pc_r, pc_rst, pc_inc, pc_push, pc_pop,
//                                data_bus_in[7:0]
//                Slave drives  : addr_bus_out[ADDR_W-1:0], addr_oe,
//                                load_pending, pc_value[ADDR_W-1:0], stk_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
    parameter int ADDR_W = 16
);
    logic              pc_w;
    logic              pc_r;
    logic              pc_rst;
    logic              pc_inc;
    logic              pc_push;
    logic              pc_pop;
    logic [7:0]        data_bus_in;
    logic [ADDR_W-1:0] addr_bus_out;
    logic              addr_oe;
    logic              load_pending;
    logic [ADDR_W-1:0] pc_value;
    logic              stk_err;

    modport master (
        output pc_w, pc_r, pc_rst, pc_inc, pc_push, pc_pop, data_bus_in,
        input  addr_bus_out, addr_oe, load_pending, pc_value, stk_err
    );

    modport slave (
        input  pc_w, pc_r, pc_rst, pc_inc, pc_push, pc_pop, data_bus_in,
        output addr_bus_out, addr_oe, load_pending, pc_value, stk_err
    );
endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : 16-bit program counter stage. Supplies the fetch address,
//                increments on pc_inc, loads a new PC from the 8-bit data bus
//                as a low-byte / high-byte pair, and soft-resets on pc_rst.
//                Optional return stack enabled by macro PC_STACK_EN.
//  Ports       : clk              - system clock, rising edge
//                rst_n            - asynchronous active-low reset
//                bus (slave)      - strobes, data_bus_in, addr_bus_out,
//                                   addr_oe, load_pending, pc_value, stk_err
//  Parameters  : ADDR_W      - PC width, must be 16
//                RESET_VEC   - PC value after rst_n or pc_rst
//                STACK_DEPTH - return stack entries (PC_STACK_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int                 ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = 16'h0000,
    parameter int                 STACK_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    pc_unit_if.slave  bus
);

    // The two-beat load concatenates exactly two bytes.
    if (ADDR_W != 16) begin : g_addr_w_check
        $error("pc_unit: ADDR_W must be 16");
    end

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_LO_HELD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        lo_hold_q, lo_hold_d;

    // Stack hooks into the main PC path.
    logic              w_pop_ok;
    logic [ADDR_W-1:0] w_pop_val;
    logic              w_stk_err;

    logic              w_first_beat;
    logic              w_commit;

    assign w_first_beat = bus.pc_w && (state_q == ST_IDLE);
    assign w_commit     = bus.pc_w && (state_q == ST_LO_HELD);

    // ------------------------------------------------------------------------
    // Main next-state logic: pc_rst > pop > load commit > increment
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        lo_hold_d = lo_hold_q;

        if (bus.pc_rst) begin
            // Any beat in this cycle is discarded along with a held low byte.
            state_d = ST_IDLE;
            pc_d    = RESET_VEC;
        end else begin
            // The load FSM advances regardless of a pop; only the PC write
            // of a commit can be overridden.
            if (w_first_beat) begin
                lo_hold_d = bus.data_bus_in;
                state_d   = ST_LO_HELD;
            end else if (w_commit) begin
                state_d = ST_IDLE;
            end

            if (w_pop_ok) begin
                pc_d = w_pop_val;
            end else if (w_commit) begin
                pc_d = {bus.data_bus_in, lo_hold_q};
            end else if (bus.pc_inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VEC;
            lo_hold_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            lo_hold_q <= lo_hold_d;
        end
    end

`ifdef PC_STACK_EN
    // ------------------------------------------------------------------------
    // Return stack: sp counts filled entries, 0..STACK_DEPTH
    // ------------------------------------------------------------------------
    localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              stk_err_q, stk_err_d;
    logic              w_push_ok;
    logic              w_pop_legal;

    // Simultaneous push and pop is treated as a fault, not a swap.
    assign w_push_ok   = bus.pc_push && !bus.pc_pop && (sp_q != SP_FULL);
    assign w_pop_legal = bus.pc_pop && !bus.pc_push && (sp_q != '0);

    always_comb begin
        sp_d      = sp_q;
        stk_err_d = stk_err_q;
        stack_d   = stack_q;
        w_pop_ok  = 1'b0;
        w_pop_val = '0;

        // Top of stack lives at sp-1; decoded by loop to keep index widths exact.
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                w_pop_val = stack_q[i];
            end
        end

        if (bus.pc_rst) begin
            sp_d      = '0;
            stk_err_d = 1'b0;
        end else if (w_push_ok) begin
            // Pushes the PC as it stands this cycle, before any load/inc.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) begin
                    stack_d[i] = pc_q;
                end
            end
            sp_d = sp_q + SP_W'(1);
        end else if (w_pop_legal) begin
            w_pop_ok = 1'b1;
            sp_d     = sp_q - SP_W'(1);
        end else if (bus.pc_push || bus.pc_pop) begin
            stk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q      <= '0;
            stk_err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            sp_q      <= sp_d;
            stk_err_q <= stk_err_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign w_stk_err = stk_err_q;
`else
    // Stack absent: push/pop strobes are accepted and ignored.
    logic unused_stack_ok;
    assign unused_stack_ok = ^{bus.pc_push, bus.pc_pop, (STACK_DEPTH > 0)};
    assign w_pop_ok        = 1'b0;
    assign w_pop_val       = '0;
    assign w_stk_err       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs: address path is combinational from pc_r and the registered PC,
    // so a fetch with pc_inc shows the pre-increment address.
    // ------------------------------------------------------------------------
    assign bus.addr_bus_out = bus.pc_r ? pc_q : '0;
    assign bus.addr_oe      = bus.pc_r;
    assign bus.load_pending = (state_q == ST_LO_HELD);
    assign bus.pc_value     = pc_q;
    assign bus.stk_err      = w_stk_err;

endmodule : pc_unit
`default_nettype wire
